// File: rtl/risc_pkg.sv
// risc_pkg: shared RV32I encodings for the multi-cycle control path.
package risc_pkg;
   localparam int RISCV_XLEN = 32;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} op_enum_ctrl_state;
   typedef enum logic [1:0] {PC_PC4, PC_TARGET, PC_ALU} op_enum_pc_sel;
   typedef enum logic [1:0] {OP_RF_SEL_ALU, OP_RF_SEL_MEM, OP_RF_SEL_PC, OP_RF_SEL_IMM} op_enum_wr_data_sel;
   typedef enum logic [2:0] {OP_SIZE_BYTE, OP_SIZE_HALF, OP_SIZE_WORD} op_enum_dmem_size;
   typedef enum logic [3:0] {
      OP_ALU_ADD  = 4'b0000, OP_ALU_SLL = 4'b0001, OP_ALU_SLT = 4'b0010, OP_ALU_SLTU = 4'b0011,
      OP_ALU_XOR  = 4'b0100, OP_ALU_SRL = 4'b0101, OP_ALU_OR  = 4'b0110, OP_ALU_AND  = 4'b0111,
      OP_ALU_SUB  = 4'b1000, OP_ALU_SRA = 4'b1101
   } op_enum_alu;

   localparam logic ALU_A_RS1 = 1'b0;
   localparam logic ALU_A_PC  = 1'b1;
   localparam logic ALU_B_RS2 = 1'b0;
   localparam logic ALU_B_IMM = 1'b1;

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;
endpackage

// File: rtl/risc_alu_dec.sv
// risc_alu_dec: {opcode, funct7[5], funct3} to ALU op, flags encodings this core cannot execute.
module risc_alu_dec
   import risc_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic       funct7_b5,
   input  logic [2:0] funct3,
   output logic [3:0] alu_op,
   output logic       illegal
);
   always_comb begin
      alu_op = OP_ALU_ADD;
      illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            alu_op = {funct7_b5, funct3};
            illegal = funct7_b5 && funct3 != 3'b000 && funct3 != 3'b101;
         end
         OPC_OP_IMM: alu_op = {funct7_b5 && funct3 == 3'b101, funct3};
         OPC_LOAD: illegal = funct3 == 3'b011 || funct3[2:1] == 2'b11;
         OPC_STORE: illegal = funct3[2] || funct3 == 3'b011;
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_SYSTEM: ;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/risc_mc_ctrl.sv
// risc_mc_ctrl: multi-cycle RV32I control FSM driving a shared datapath.
// Define RISC_CTRL_PERF_EN to build the cycle/instret counters.
module risc_mc_ctrl
   import risc_pkg::*;
#(
   parameter int XLEN = RISCV_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     instr,
   input  logic            br_cond,
   output logic            imem_req,
   input  logic            imem_ready,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [2:0]      dmem_size,
   output logic            dmem_unsigned,
   input  logic            dmem_ready,
   output logic            ir_we,
   output logic            pc_we,
   output logic [1:0]      pc_sel,
   output logic [3:0]      alu_op,
   output logic            alu_src_a,
   output logic            alu_src_b,
   output logic            rf_we,
   output logic [1:0]      rf_wr_sel,
   output logic            illegal,
   output logic [XLEN-1:0] cycle_cnt,
   output logic [XLEN-1:0] instret_cnt
);
   op_enum_ctrl_state state, state_nxt;
   logic [6:0] opc;
   logic [2:0] f3;
   logic [3:0] dec_alu;
   logic is_load, is_store, is_mem, bad_f7, dec_illegal, unused_instr;

   assign opc = instr[6:0];
   assign f3 = instr[14:12];
   assign is_load = opc == OPC_LOAD;
   assign is_store = opc == OPC_STORE;
   assign is_mem = is_load || is_store;
   assign bad_f7 = opc == OPC_OP && (instr[31] || |instr[29:25]);
   assign unused_instr = ^{instr[24:15], instr[11:7]};
   assign illegal = state == TRAP;

   risc_alu_dec u_alu_dec (
      .opcode    (opc),
      .funct7_b5 (instr[30]),
      .funct3    (f3),
      .alu_op    (dec_alu),
      .illegal   (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= FETCH;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   state_nxt = imem_ready ? DECODE : FETCH;
         DECODE:  state_nxt = (dec_illegal || bad_f7) ? TRAP : EXEC;
         EXEC:    state_nxt = is_mem ? MEM : FETCH;
         MEM:     state_nxt = dmem_ready ? (is_store ? FETCH : WB) : MEM;
         WB:      state_nxt = FETCH;
         default: state_nxt = TRAP;
      endcase
   end

   // Gating on rst_n drops any outstanding request the moment reset asserts.
   always_comb begin
      imem_req = 1'b0;
      ir_we = 1'b0;
      pc_we = 1'b0;
      pc_sel = PC_PC4;
      alu_op = OP_ALU_ADD;
      alu_src_a = ALU_A_RS1;
      alu_src_b = ALU_B_RS2;
      rf_we = 1'b0;
      rf_wr_sel = OP_RF_SEL_ALU;
      dmem_req = 1'b0;
      dmem_we = 1'b0;
      dmem_size = OP_SIZE_BYTE;
      dmem_unsigned = 1'b0;
      if (rst_n) begin
         case (state)
            FETCH: begin
               imem_req = 1'b1;
               ir_we = imem_ready;
            end
            EXEC: begin
               alu_op = dec_alu;
               alu_src_a = opc == OPC_AUIPC ? ALU_A_PC : ALU_A_RS1;
               alu_src_b = (opc == OPC_OP || opc == OPC_BRANCH) ? ALU_B_RS2 : ALU_B_IMM;
               rf_we = !(is_mem || opc == OPC_BRANCH || opc == OPC_SYSTEM);
               rf_wr_sel = opc == OPC_LUI ? OP_RF_SEL_IMM :
                           (opc == OPC_JAL || opc == OPC_JALR) ? OP_RF_SEL_PC : OP_RF_SEL_ALU;
               pc_we = !is_mem;
               pc_sel = opc == OPC_JAL ? PC_TARGET :
                        opc == OPC_JALR ? PC_ALU :
                        (opc == OPC_BRANCH && br_cond) ? PC_TARGET : PC_PC4;
            end
            MEM: begin
               alu_src_b = ALU_B_IMM;
               dmem_req = 1'b1;
               dmem_we = is_store;
               dmem_size = f3[1:0] == 2'b00 ? OP_SIZE_BYTE :
                           f3[1:0] == 2'b01 ? OP_SIZE_HALF : OP_SIZE_WORD;
               dmem_unsigned = is_load && f3[2];
               pc_we = is_store && dmem_ready;
            end
            WB: begin
               rf_we = 1'b1;
               rf_wr_sel = OP_RF_SEL_MEM;
               pc_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef RISC_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cycle_cnt <= '0;
         instret_cnt <= '0;
      end else if (state != TRAP) begin
         cycle_cnt <= cycle_cnt + XLEN'(1);
         instret_cnt <= instret_cnt + XLEN'(pc_we);
      end
`else
   assign cycle_cnt = '0;
   assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_risc_mc_ctrl.sv
// tb_risc_mc_ctrl: directed plus randomized instruction stream against an instruction-level model.
module tb_risc_mc_ctrl;
   import risc_pkg::*;

`ifdef RISC_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic br_cond = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic imem_req, dmem_req, dmem_we, dmem_unsigned, ir_we, pc_we, alu_src_a, alu_src_b, rf_we, illegal;
   logic [2:0] dmem_size;
   logic [1:0] pc_sel, rf_wr_sel;
   logic [3:0] alu_op;
   logic [31:0] cycle_cnt, instret_cnt;
   logic [20:0] obs, m_ctrl;
   logic [31:0] n_cyc, n_ret;
   int vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   risc_mc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .br_cond(br_cond),
      .imem_req(imem_req), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
      .dmem_unsigned(dmem_unsigned), .dmem_ready(dmem_ready),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_we(rf_we), .rf_wr_sel(rf_wr_sel),
      .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   assign obs = {imem_req, ir_we, pc_we, pc_sel, alu_op, alu_src_a, alu_src_b, rf_we, rf_wr_sel,
                 dmem_req, dmem_we, dmem_size, dmem_unsigned, illegal};

   function automatic logic [20:0] vec(logic ireq, logic irwe, logic pcwe, logic [1:0] pcsel,
                                       logic [3:0] alu, logic sa, logic sb, logic rfwe, logic [1:0] wsel,
                                       logic dreq, logic dwe, logic [2:0] dsz, logic duns, logic ill);
      return {ireq, irwe, pcwe, pcsel, alu, sa, sb, rfwe, wsel, dreq, dwe, dsz, duns, ill};
   endfunction

   function automatic logic [3:0] alu_of(logic [2:0] f3);
      case (f3)
         3'd0: return OP_ALU_ADD;
         3'd1: return OP_ALU_SLL;
         3'd2: return OP_ALU_SLT;
         3'd3: return OP_ALU_SLTU;
         3'd4: return OP_ALU_XOR;
         3'd5: return OP_ALU_SRL;
         3'd6: return OP_ALU_OR;
         default: return OP_ALU_AND;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      case ($urandom_range(0, 9))
         0: begin
            r[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
            r[14:12] = f3;
            r[6:0] = OPC_OP;
         end
         1: begin r[14:12] = f3; r[6:0] = OPC_OP_IMM; end
         2: r[6:0] = OPC_LUI;
         3: r[6:0] = OPC_AUIPC;
         4: r[6:0] = OPC_JAL;
         5: begin r[14:12] = 3'd0; r[6:0] = OPC_JALR; end
         6: r[6:0] = OPC_BRANCH;
         7: begin r[14:12] = ld_f3[$urandom_range(0, 4)]; r[6:0] = OPC_LOAD; end
         8: begin r[14:12] = 3'($urandom_range(0, 2)); r[6:0] = OPC_STORE; end
         default: r[6:0] = OPC_SYSTEM;
      endcase
      return r;
   endfunction

   // One clock: drive inputs at the falling edge, check just after, then advance to the next falling edge.
   task automatic cyc(input logic [20:0] e, input logic [20:0] m, input logic imr, input logic dmr,
                      input logic [31:0] ins, input logic br, input string tag);
      logic [31:0] ec, er;
      imem_ready = imr;
      dmem_ready = dmr;
      instr = ins;
      br_cond = br;
      #1;
      vectors++;
      assert ((obs & m) === (e & m)) else begin
         miscompares++;
         $error("FAIL %s: ctrl got %h expected %h", tag, obs & m, e & m);
      end
      ec = PERF ? n_cyc : 32'd0;
      er = PERF ? n_ret : 32'd0;
      vectors++;
      assert (cycle_cnt === ec && instret_cnt === er) else begin
         miscompares++;
         $error("FAIL %s_cnt: got %0d/%0d expected %0d/%0d", tag, cycle_cnt, instret_cnt, ec, er);
      end
      if (!e[0]) n_cyc++;
      if (e[18]) n_ret++;
      @(negedge clk);
   endtask

   task automatic reset_chk(input string tag);
      rst_n = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      vectors++;
      assert ({obs, cycle_cnt, instret_cnt} === '0) else begin
         miscompares++;
         $error("FAIL %s: got %h/%0d/%0d expected all zero", tag, obs, cycle_cnt, instret_cnt);
      end
      n_cyc = 0;
      n_ret = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run(input logic [31:0] ins, input logic br, input int iw, input int dw, input bit cut);
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      logic ld = op == OPC_LOAD, st = op == OPC_STORE;
      logic ok, rfwe, care, un;
      logic [1:0] pcsel, wsel;
      logic [2:0] sz;
      logic [3:0] alu = OP_ALU_ADD;
      logic [20:0] m;
      case (op)
         OPC_OP: ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         OPC_LOAD: ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         OPC_STORE: ok = f3 <= 3'd2;
         OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_SYSTEM: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      if (op == OPC_OP) alu = f7 == 7'h20 ? (f3 == 3'd0 ? OP_ALU_SUB : OP_ALU_SRA) : alu_of(f3);
      if (op == OPC_OP_IMM) alu = (f3 == 3'd5 && ins[30]) ? OP_ALU_SRA : alu_of(f3);
      for (int i = 0; i < iw; i++)
         cyc(vec(1,0,0,0,0,0,0,0,0,0,0,0,0,0), m_ctrl, 1'b0, 1'($urandom), $urandom, 1'($urandom), "fetch_wait");
      cyc(vec(1,1,0,0,0,0,0,0,0,0,0,0,0,0), m_ctrl, 1'b1, 1'($urandom), $urandom, 1'($urandom), "fetch");
      cyc('0, m_ctrl, 1'($urandom), 1'($urandom), ins, 1'($urandom), "decode");
      if (!ok) begin
         for (int i = 0; i < 100; i++)
            cyc(vec(0,0,0,0,0,0,0,0,0,0,0,0,0,1), m_ctrl, 1'($urandom), 1'($urandom), ins, 1'($urandom), "trap");
         return;
      end
      rfwe = op inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
      care = op inside {OPC_OP, OPC_OP_IMM, OPC_AUIPC, OPC_JALR, OPC_LOAD, OPC_STORE};
      wsel = op == OPC_LUI ? OP_RF_SEL_IMM : (op == OPC_JAL || op == OPC_JALR) ? OP_RF_SEL_PC : OP_RF_SEL_ALU;
      pcsel = op == OPC_JAL ? PC_TARGET : op == OPC_JALR ? PC_ALU : (op == OPC_BRANCH && br) ? PC_TARGET : PC_PC4;
      m = m_ctrl | vec(0,0,0, !(ld||st) ? 2'b11 : 2'b00, care ? 4'hF : 4'h0, care, care, 0,
                       rfwe ? 2'b11 : 2'b00, 0,0,3'b0,0,0);
      cyc(vec(0,0,!(ld||st),pcsel,alu,op == OPC_AUIPC,op != OPC_OP,rfwe,wsel,0,0,0,0,0), m,
          1'($urandom), 1'($urandom), ins, br, "exec");
      if (!(ld || st)) return;
      sz = f3[1:0] == 2'd0 ? OP_SIZE_BYTE : f3[1:0] == 2'd1 ? OP_SIZE_HALF : OP_SIZE_WORD;
      un = ld && f3[2];
      m = m_ctrl | vec(0,0,0,0,0,0,0,0,0,0,1,3'b111,1,0);
      for (int i = 0; i < dw; i++)
         cyc(vec(0,0,0,0,0,0,0,0,0,1,st,sz,un,0), m, 1'($urandom), 1'b0, ins, 1'($urandom), "mem_wait");
      if (cut) return;
      cyc(vec(0,0,st,PC_PC4,0,0,0,0,0,1,st,sz,un,0), m | (st ? vec(0,0,0,2'b11,0,0,0,0,0,0,0,0,0,0) : '0),
          1'($urandom), 1'b1, ins, 1'($urandom), "mem");
      if (ld)
         cyc(vec(0,0,1,PC_PC4,0,0,0,1,OP_RF_SEL_MEM,0,0,0,0,0), m_ctrl | vec(0,0,0,2'b11,0,0,0,0,2'b11,0,0,0,0,0),
             1'($urandom), 1'($urandom), ins, 1'($urandom), "wb");
   endtask

   initial begin
      m_ctrl = vec(1,1,1,0,0,0,0,1,0,1,0,0,0,1);
      n_cyc = 0;
      n_ret = 0;
      reset_chk("reset");
      run(32'h002081B3, 1'b0, 0, 0, 1'b0);
      run(32'h0040A283, 1'b0, 0, 2, 1'b0);
      run(32'h00208023, 1'b0, 1, 0, 1'b0);
      run(32'h00208463, 1'b1, 0, 0, 1'b0);
      run(32'h00208463, 1'b0, 2, 0, 1'b0);
      run(32'h000100E7, 1'b0, 0, 0, 1'b0);
      reset_chk("reset_perf");
      repeat (10) run(32'h002081B3, 1'b0, 0, 0, 1'b0);
      vectors++;
      assert (cycle_cnt === (PERF ? 32'd30 : 32'd0) && instret_cnt === (PERF ? 32'd10 : 32'd0)) else begin
         miscompares++;
         $error("FAIL perf_10_add: got %0d/%0d expected %0d/%0d", cycle_cnt, instret_cnt,
                PERF ? 30 : 0, PERF ? 10 : 0);
      end
      for (int i = 0; i < 300; i++)
         run(rand_instr(), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      run(32'h0000007F, 1'b0, 0, 0, 1'b0);
      reset_chk("reset_after_bad_opcode");
      run(32'h022081B3, 1'b0, 1, 0, 1'b0);
      reset_chk("reset_after_bad_funct7");
      run(32'h0040A283, 1'b0, 0, 2, 1'b1);
      #3;
      reset_chk("reset_mid_mem");
      run(32'h0040A283, 1'b0, 0, 1, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
